// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and default widths for the MEM stage
package mem_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int REG_W_DEF  = 3;

    // Request fields are sized for the widest supported build; users slice to their width.
    localparam int DATA_W_MAX = 64;
    localparam int IDX_W_MAX  = 32;
    localparam int REG_W_MAX  = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic                  rd;
        logic                  wr;
        logic                  m2r;
        logic [IDX_W_MAX-1:0]  idx;
        logic [DATA_W_MAX-1:0] wdata;
        logic [DATA_W_MAX-1:0] alu;
        logic [REG_W_MAX-1:0]  rd_idx;
        logic                  regwr;
    } mem_req_t;

endpackage

// File: rtl/mem_stage_pipe_mem.sv
// rtl/mem_stage_pipe_mem.sv - word-addressed data memory, sync write, async read
module data_mem_array #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/mem_stage_pipe.sv
// rtl/mem_stage_pipe.sv - MEM stage with multi-cycle data memory and MEM/WB register
// Optional address range check: MEM_ADDR_CHECK_EN
module mem_stage_pipe
    import mem_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 256,
    parameter int MEM_LAT = 2,
    parameter int REG_W   = REG_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_to_reg,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] alu_data,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              reg_write_in,
    input  logic              flush,
    output logic              stall,
    output logic              wb_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [REG_W-1:0]  wb_rd,
    output logic              wb_reg_write,
    output logic              addr_err
);

    localparam int         IDX_W  = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    state_t   state;
    logic [3:0] cnt;
    mem_req_t req;

    logic              busy, accept, is_mem, done, we;
    logic              cur_wr, cur_m2r, cur_regwr, cur_oob;
    logic [IDX_W-1:0]  cur_idx;
    logic [DATA_W-1:0] cur_wdata, cur_alu, rdata;
    logic [REG_W-1:0]  cur_rd_idx;

    assign busy  = (state == BUSY);
    assign stall = busy;

    // In IDLE the op may complete at its own acceptance edge, so it is served from the live inputs.
    assign cur_wr     = busy ? req.wr                    : mem_write;
    assign cur_m2r    = busy ? req.m2r                   : mem_to_reg;
    assign cur_regwr  = busy ? req.regwr                 : reg_write_in;
    assign cur_idx    = busy ? req.idx[IDX_W-1:0]        : addr[IDX_W-1:0];
    assign cur_wdata  = busy ? req.wdata[DATA_W-1:0]     : write_data;
    assign cur_alu    = busy ? req.alu[DATA_W-1:0]       : alu_data;
    assign cur_rd_idx = busy ? req.rd_idx[REG_W-1:0]     : rd_in;

    assign accept = !busy && in_valid && !flush;
    assign is_mem = mem_read || mem_write;
    assign done   = busy ? (cnt == 4'd0 && !flush)
                         : (accept && (!is_mem || MEM_LAT == 0));
    assign we     = done && cur_wr && !cur_oob;

`ifdef MEM_ADDR_CHECK_EN
    logic in_oob, req_oob;
    assign in_oob  = ((addr >> IDX_W) != '0);
    assign cur_oob = busy ? req_oob : in_oob;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_oob  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= done && cur_oob;
            if (accept) begin
                req_oob <= in_oob;
            end
        end
    end
`else
    assign cur_oob  = 1'b0;
    assign addr_err = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{req, addr};

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .idx   (cur_idx),
        .wdata (cur_wdata),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 4'd0;
            req          <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
        end else begin
            wb_valid <= done;
            if (done) begin
                wb_data      <= cur_m2r ? (cur_oob ? '0 : rdata) : cur_alu;
                wb_rd        <= cur_rd_idx;
                wb_reg_write <= cur_regwr;
            end
            if (busy) begin
                if (flush || cnt == 4'd0) begin
                    state <= IDLE;
                    cnt   <= 4'd0;
                end else begin
                    cnt <= cnt - 4'd1;
                end
            end else if (accept) begin
                req.rd     <= mem_read;
                req.wr     <= mem_write;
                req.m2r    <= mem_to_reg;
                req.idx    <= IDX_W_MAX'(addr[IDX_W-1:0]);
                req.wdata  <= DATA_W_MAX'(write_data);
                req.alu    <= DATA_W_MAX'(alu_data);
                req.rd_idx <= REG_W_MAX'(rd_in);
                req.regwr  <= reg_write_in;
                if (is_mem && MEM_LAT != 0) begin
                    state <= BUSY;
                    cnt   <= LAT_M1;
                end
            end
        end
    end

endmodule
